// File: rtl/RSA_pkg.sv
// Shared RSA datapath definitions: default modulus width, key word type and
// the Montgomery multiplier state encoding.
package RSA_pkg;

  localparam int unsigned MOD_WIDTH = 256;

  typedef logic [MOD_WIDTH-1:0] KeyType;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOP  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } MontState_t;

endpackage

// File: rtl/rsa_mont_step.sv
// One radix-2 Montgomery iteration: conditionally add b, add n to make the sum
// even, then halve.
// Ports:
//   acc        in  WIDTH+2  running accumulator, < 2N
//   a_bit      in  1        current multiplier bit
//   b          in  WIDTH    multiplicand
//   n          in  WIDTH    odd modulus
//   acc_next_c out WIDTH+2  (acc + a_bit*b + q*n) / 2, still < 2N
module rsa_mont_step
  import RSA_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH+1:0] acc,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] acc_next_c
);

  localparam int unsigned ACC_W = WIDTH + 2;

  logic [ACC_W-1:0] t0_c;
  logic [ACC_W-1:0] t1_c;

  // acc < 2N, b < N, n < N  ->  sum < 4N < 2^(WIDTH+2): no carry lost.
  always_comb begin
    t0_c       = acc + (a_bit ? ACC_W'(b) : ACC_W'(0));
    t1_c       = t0_c + (t0_c[0] ? ACC_W'(n) : ACC_W'(0));
    acc_next_c = t1_c >> 1;
  end

endmodule

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: o_out = i_a * i_b * 2^(-WIDTH) mod i_modulus.
// One multiplier bit per cycle, then a single conditional final subtract.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   i_valid/i_ready   operand handshake (ready only while idle)
//   i_a, i_b          operands, each < i_modulus
//   i_modulus         odd modulus N
//   o_valid/o_ready   result handshake, result held until accepted
//   o_out             Montgomery product
module rsa_mont_mul
  import RSA_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_modulus,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_out
);

  localparam int unsigned ACC_W = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  MontState_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_step_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             i_ready_q, i_ready_d;
  logic             o_valid_q, o_valid_d;

  rsa_mont_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_q),
    .a_bit      (a_sh_q[0]),
    .b          (b_q),
    .n          (n_q),
    .acc_next_c (acc_step_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = LOOP;
      LOOP:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake outputs; flags track the state being entered so
  // they change on the same edge as the state.
  always_comb begin
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    n_d       = n_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    i_ready_d = (state_d == IDLE);
    o_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_sh_d = i_a;
          b_d    = i_b;
          n_d    = i_modulus;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      LOOP: begin
        acc_d  = acc_step_c;
        a_sh_d = a_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      FINAL: begin
        if (acc_q >= ACC_W'(n_q)) acc_d = acc_q - ACC_W'(n_q);
      end
      default: ;
    endcase
  end

  // Datapath and handshake flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh_q    <= '0;
      b_q       <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_out   = acc_q[WIDTH-1:0];

endmodule

// File: tb/tb_rsa_mont_mul.sv
// Directed bench for rsa_mont_mul at WIDTH=8, N=13 (R^-1 mod 13 = 3).
module tb_rsa_mont_mul;

  localparam int unsigned W = 8;
  localparam int unsigned N = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic [W-1:0] i_modulus;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_out;

  int checks   = 0;
  int failures = 0;

  rsa_mont_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_modulus (i_modulus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency/busy/result, optionally stall the
  // result and pulse i_valid while busy, then accept the result.
  task automatic run_op(input string tag, input int a, input int b, input int exp,
                        input int stall, input bit pulse);
    int lat;
    bit busy_ok;
    chk({tag, "_rdy_before"}, 32'(i_ready), 32'd1);
    i_a     = W'(a);
    i_b     = W'(b);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      if (pulse && lat == 2) begin
        i_a = 8'd12; i_b = 8'd12; i_valid = 1'b1;
      end
      if (pulse && lat == 5) i_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!o_valid && i_ready) busy_ok = 1'b0;
    end while (!o_valid && lat < 40);
    i_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_rdy_low"}, 32'(busy_ok), 32'd1);
    chk({tag, "_out"}, 32'(o_out), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_stall_out"}, 32'(o_out), 32'(exp));
      chk({tag, "_stall_rdy"}, 32'(i_ready), 32'd0);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(i_ready), 32'd1);
  endtask

  initial begin
    int ra, rb;
    rst       = 1'b0;
    i_valid   = 1'b0;
    o_ready   = 1'b0;
    i_a       = '0;
    i_b       = '0;
    i_modulus = W'(N);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(i_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_out", 32'(o_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic products.
    run_op("t1_5x7", 5, 7, 1, 0, 1'b0);
    run_op("t2_5xR2", 5, 3, 6, 0, 1'b0);
    run_op("t2_0x12", 0, 12, 0, 0, 1'b0);
    run_op("t2_1x1", 1, 1, 3, 0, 1'b0);
    run_op("t3_12x12", 12, 12, 3, 0, 1'b0);

    // Output stall plus i_valid pulsed while busy.
    run_op("t4_stall", 5, 7, 1, 5, 1'b1);

    // Reset mid-loop abandons the computation.
    i_a = 8'd5; i_b = 8'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_valid", 32'(o_valid), 32'd0);
    chk("t5_rst_rdy", 32'(i_ready), 32'd1);
    chk("t5_rst_out", 32'(o_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("t5_after", 5, 7, 1, 0, 1'b0);

    // Random operands with random result stalls.
    for (int k = 0; k < 20; k++) begin
      ra = int'($urandom_range(0, N - 1));
      rb = int'($urandom_range(0, N - 1));
      run_op("t6_rand", ra, rb, (ra * rb * 3) % N, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
